// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the frame state encoding, parity mode codes and the parity function.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Parity bit for a zero-extended word; unused upper bits must be zero.
   function automatic logic parity_bit(input logic [15:0] word, input int mode);
      return (mode == PARITY_ODD) ? ~(^word) : (^word);
   endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// end_next_o looks one cycle ahead so the transmitter can register tx_done.
module uart_baud_div #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic bit_end_o,
   output logic end_next_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end_o = (cnt_q == LAST);

   // Wrapping at bit_end keeps every state change aligned to a fresh count.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || bit_end_o) begin
         cnt_d = '0;
      end
   end

   assign end_next_o = (cnt_d == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Words are accepted over send/ready; all outputs come straight from registers.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  ready,
   output logic                  txd,
   output logic                  tx_done
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_e             state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [BW-1:0]         bit_cnt_q;
   logic                  parity_q;
   logic                  txd_q;
   logic                  ready_q;
   logic                  done_q;
   logic                  div_clr;
   logic                  bit_end;
   logic                  end_next;

   // Divider is held at zero while idle, so the start bit begins on a clean count.
   assign div_clr = (state_q == IDLE);

   uart_baud_div #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_div (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (div_clr),
      .bit_end_o  (bit_end),
      .end_next_o (end_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         txd_q     <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (send) begin
                  state_q  <= START;
                  shift_q  <= data;
                  parity_q <= parity_bit(16'(data), PARITY_MODE);
                  txd_q    <= 1'b0;
                  ready_q  <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state_q   <= DATA;
                  bit_cnt_q <= '0;
                  txd_q     <= shift_q[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt_q == LAST_DATA) begin
                     if (PARITY_MODE != PARITY_NONE) begin
                        state_q <= PARITY;
                        txd_q   <= parity_q;
                     end else begin
                        state_q   <= STOP;
                        txd_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        done_q    <= (STOP_BITS == 1) && end_next;
                     end
                  end else begin
                     shift_q   <= shift_q >> 1;
                     txd_q     <= shift_q[1];
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state_q   <= STOP;
                  txd_q     <= 1'b1;
                  bit_cnt_q <= '0;
                  done_q    <= (STOP_BITS == 1) && end_next;
               end
            end
            STOP: begin
               // tx_done is set one edge early so it lands on the final stop cycle.
               if (bit_end) begin
                  if (bit_cnt_q == LAST_STOP) begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                     done_q    <= ((bit_cnt_q + BW'(1)) == LAST_STOP) && end_next;
                  end
               end else begin
                  done_q <= (bit_cnt_q == LAST_STOP) && end_next;
               end
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign txd     = txd_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations checked cycle by cycle against
// an expected serial frame built from the data word, parity mode and stop count.
module tb_uart_tx_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        send_v  [4];
   logic [15:0] data_v  [4];
   logic        txd_v   [4];
   logic        ready_v [4];
   logic        done_v  [4];

   // Per-instance configuration: plain, even parity, odd parity, 5-bit/2-stop/1-clk.
   int dw_a [4] = '{8, 8, 8, 5};
   int c_a  [4] = '{4, 4, 4, 1};
   int pm_a [4] = '{0, 1, 2, 0};
   int sb_a [4] = '{1, 1, 1, 2};

   int   total  = 0;
   int   passed = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_tx_param u_plain (
      .clk(clk), .rst(rst), .send(send_v[0]), .data(data_v[0][7:0]),
      .ready(ready_v[0]), .txd(txd_v[0]), .tx_done(done_v[0])
   );

   uart_tx_param #(.PARITY_MODE(1)) u_even (
      .clk(clk), .rst(rst), .send(send_v[1]), .data(data_v[1][7:0]),
      .ready(ready_v[1]), .txd(txd_v[1]), .tx_done(done_v[1])
   );

   uart_tx_param #(.PARITY_MODE(2)) u_odd (
      .clk(clk), .rst(rst), .send(send_v[2]), .data(data_v[2][7:0]),
      .ready(ready_v[2]), .txd(txd_v[2]), .tx_done(done_v[2])
   );

   uart_tx_param #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .STOP_BITS(2)) u_small (
      .clk(clk), .rst(rst), .send(send_v[3]), .data(data_v[3][4:0]),
      .ready(ready_v[3]), .txd(txd_v[3]), .tx_done(done_v[3])
   );

   task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
   endtask

   // Frame as a list of serial bits: start, data LSB first, parity, stop bits.
   task automatic model_frame(input int d, input logic [15:0] w);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < dw_a[d]; i++) begin
         exp_q.push_back(w[i]);
         if (w[i]) ones++;
      end
      if (pm_a[d] == 1) exp_q.push_back((ones % 2) == 1);
      if (pm_a[d] == 2) exp_q.push_back((ones % 2) == 0);
      for (int i = 0; i < sb_a[d]; i++) exp_q.push_back(1'b1);
   endtask

   // Caller has set send/data during an idle cycle; the accept happens at the next edge.
   task automatic run_frame(input int d, input logic [15:0] w, input logic send_after,
                            input logic [15:0] data_after, input int pulse_k);
      int c;
      int f;
      model_frame(d, w);
      c = c_a[d];
      f = exp_q.size() * c;
      @(negedge clk);
      send_v[d] = send_after;
      data_v[d] = data_after;
      for (int k = 1; k <= f; k++) begin
         chk("txd", k, 16'(txd_v[d]), 16'(exp_q[(k - 1) / c]));
         chk("ready", k, 16'(ready_v[d]), 16'd0);
         chk("tx_done", k, 16'(done_v[d]), (k == f) ? 16'd1 : 16'd0);
         if (pulse_k > 0 && k == pulse_k) send_v[d] = 1'b1;
         if (pulse_k > 0 && k == pulse_k + 1) send_v[d] = 1'b0;
         @(negedge clk);
      end
      chk("idle_txd", f + 1, 16'(txd_v[d]), 16'd1);
      chk("idle_ready", f + 1, 16'(ready_v[d]), 16'd1);
      chk("idle_done", f + 1, 16'(done_v[d]), 16'd0);
   endtask

   initial begin
      logic [15:0] w;
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         send_v[d] = 1'b0;
         data_v[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         chk("rst_txd", d, 16'(txd_v[d]), 16'd1);
         chk("rst_ready", d, 16'(ready_v[d]), 16'd1);
         chk("rst_done", d, 16'(done_v[d]), 16'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Directed frames; data is scrambled right after accept to show it is latched.
      send_v[0] = 1'b1; data_v[0] = 16'h00A5;
      run_frame(0, 16'h00A5, 1'b0, 16'h005A, 0);
      send_v[1] = 1'b1; data_v[1] = 16'h0007;
      run_frame(1, 16'h0007, 1'b0, 16'h00F8, 0);
      send_v[2] = 1'b1; data_v[2] = 16'h0007;
      run_frame(2, 16'h0007, 1'b0, 16'h00F8, 0);
      send_v[3] = 1'b1; data_v[3] = 16'h0013;
      run_frame(3, 16'h0013, 1'b0, 16'h000C, 0);

      // Held send: two frames one idle cycle apart, then a mid-frame pulse is ignored.
      send_v[0] = 1'b1; data_v[0] = 16'h0001;
      run_frame(0, 16'h0001, 1'b1, 16'h0002, 0);
      run_frame(0, 16'h0002, 1'b0, 16'h0055, 10);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("no_third_ready", k, 16'(ready_v[0]), 16'd1);
         chk("no_third_txd", k, 16'(txd_v[0]), 16'd1);
      end

      // Reset during data bit 3 abandons the frame without tx_done.
      w = 16'($urandom_range(0, 255));
      model_frame(0, w);
      send_v[0] = 1'b1; data_v[0] = w;
      @(negedge clk);
      send_v[0] = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         chk("pre_rst_txd", k, 16'(txd_v[0]), 16'(exp_q[(k - 1) / 4]));
         if (k < 18) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_txd", 0, 16'(txd_v[0]), 16'd1);
      chk("mid_rst_ready", 0, 16'(ready_v[0]), 16'd1);
      chk("mid_rst_done", 0, 16'(done_v[0]), 16'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", 0, 16'(done_v[0]), 16'd0);
      chk("post_rst_txd", 0, 16'(txd_v[0]), 16'd1);
      w = 16'($urandom_range(0, 255));
      send_v[0] = 1'b1; data_v[0] = w;
      run_frame(0, w, 1'b0, 16'($urandom_range(0, 255)), 0);

      // Reset held with send high: nothing is accepted.
      rst = 1'b1;
      send_v[0] = 1'b1;
      data_v[0] = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_send_txd", k, 16'(txd_v[0]), 16'd1);
         chk("rst_send_ready", k, 16'(ready_v[0]), 16'd1);
         chk("rst_send_done", k, 16'(done_v[0]), 16'd0);
      end
      rst = 1'b0;
      send_v[0] = 1'b0;
      @(negedge clk);
      chk("rst_rel_txd", 0, 16'(txd_v[0]), 16'd1);
      chk("rst_rel_ready", 0, 16'(ready_v[0]), 16'd1);

      // Random words on every configuration.
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 4; d++) begin
            w = 16'($urandom_range(0, (1 << dw_a[d]) - 1));
            send_v[d] = 1'b1;
            data_v[d] = w;
            run_frame(d, w, 1'b0, 16'($urandom_range(0, 65535)), 0);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
